// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op codes and FSM state encoding shared by the sequential ALU and decoder
package alu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;
    localparam logic [2:0] ALU_DIV = 3'b101;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIV_RUN = 2'd1,
        DONE    = 2'd2
    } alu_state_t;

endpackage

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - unsigned restoring divider core, one quotient bit per step
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient_next,
    output logic [WIDTH-1:0] remainder_next,
    output logic             last
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] div_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             q_bit;

    // Extra top bit on the trial subtraction acts as the borrow / restore flag.
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        trial   = shifted - {1'b0, div_q};
        q_bit   = ~trial[WIDTH];
        remainder_next = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        quotient_next  = {quo_q[WIDTH-2:0], q_bit};
    end

    assign last = (count_q == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_q   <= '0;
            quo_q   <= '0;
            div_q   <= '0;
            count_q <= '0;
        end else if (load) begin
            rem_q   <= '0;
            quo_q   <= dividend;
            div_q   <= divisor;
            count_q <= '0;
        end else if (step) begin
            rem_q   <= remainder_next;
            quo_q   <= quotient_next;
            count_q <= count_q + CW'(1);
        end
    end

endmodule

// File: rtl/alu_seq_unit.sv
// rtl/alu_seq_unit.sv - sequential ALU with single-cycle logic/arith ops and iterative signed DIV
module alu_seq_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] remainder,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);
    alu_state_t state, state_next;

    logic             accept;
    logic             div_load;
    logic             div_step;
    logic             quick_done;
    logic             div_done;
    logic             div_last;
    logic             q_neg;
    logic             r_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic [WIDTH-1:0] quick_result;
    logic [WIDTH-1:0] quick_rem;
    logic             quick_dbz;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start && alu_control == ALU_DIV && b != '0) state_next = DIV_RUN;
            DIV_RUN: if (div_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        accept     = (state == IDLE) && start;
        div_load   = accept && (alu_control == ALU_DIV) && (b != '0);
        quick_done = accept && !div_load;
        div_step   = (state == DIV_RUN);
        div_done   = div_step && div_last;
    end

    // DIV here is only reached with b == 0; nonzero divisors go to the iterative core.
    always_comb begin
        quick_result = '0;
        quick_rem    = '0;
        quick_dbz    = 1'b0;
        case (alu_control)
            ALU_AND: quick_result = a & b;
            ALU_OR:  quick_result = a | b;
            ALU_ADD: quick_result = a + b;
            ALU_SUB: quick_result = a - b;
            ALU_SLT: quick_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_DIV: begin
                quick_result = '1;
                quick_rem    = a;
                quick_dbz    = 1'b1;
            end
            default: quick_result = '0;
        endcase
    end

    // The most negative value maps to itself, which is its correct unsigned magnitude.
    assign a_mag = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
    assign b_mag = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
    assign q_fix = q_neg ? (~quo_next + WIDTH'(1)) : quo_next;
    assign r_fix = r_neg ? (~rem_next + WIDTH'(1)) : rem_next;

    seq_divider #(.WIDTH(WIDTH)) u_div (
        .clk            (clk),
        .reset          (reset),
        .load           (div_load),
        .step           (div_step),
        .dividend       (a_mag),
        .divisor        (b_mag),
        .quotient_next  (quo_next),
        .remainder_next (rem_next),
        .last           (div_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result      <= '0;
            remainder   <= '0;
            zero        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
        end else begin
            done <= quick_done | div_done;
            if (div_load) begin
                busy  <= 1'b1;
                q_neg <= a[WIDTH-1] ^ b[WIDTH-1];
                r_neg <= a[WIDTH-1];
            end
            if (quick_done) begin
                result      <= quick_result;
                remainder   <= quick_rem;
                zero        <= (quick_result == '0);
                div_by_zero <= quick_dbz;
            end
            if (div_done) begin
                busy        <= 1'b0;
                result      <= q_fix;
                remainder   <= r_fix;
                zero        <= (q_fix == '0);
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq_unit.sv
// tb/tb_alu_seq_unit.sv - self-checking bench for alu_seq_unit against a behavioural model
module tb_alu_seq_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   alu_control = 3'b000;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] result;
    logic [W-1:0] remainder;
    logic         zero;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    int errors = 0;
    int checks = 0;

    alu_seq_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .alu_control (alu_control),
        .a           (a),
        .b           (b),
        .result      (result),
        .remainder   (remainder),
        .zero        (zero),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference arithmetic in 64-bit signed so that MIN / -1 cannot overflow.
    task automatic golden(input logic [2:0] c, input logic [W-1:0] x, input logic [W-1:0] y,
                          output logic [W-1:0] r, output logic [W-1:0] rm,
                          output logic dz, output logic multi);
        longint sx, sy, q, m;
        r = '0; rm = '0; dz = 1'b0; multi = 1'b0;
        case (c)
            3'b000: r = x & y;
            3'b001: r = x | y;
            3'b010: r = x + y;
            3'b110: r = x - y;
            3'b111: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            3'b101: begin
                if (y == 0) begin
                    r = '1; rm = x; dz = 1'b1;
                end else begin
                    sx = longint'($signed(x));
                    sy = longint'($signed(y));
                    q = sx / sy;
                    m = sx % sy;
                    r = q[W-1:0];
                    rm = m[W-1:0];
                    multi = 1'b1;
                end
            end
            default: r = '0;
        endcase
    endtask

    logic [W-1:0] m_result = '0, m_rem = '0, p_result = '0, p_rem = '0;
    logic         m_zero = 1'b0, m_busy = 1'b0, m_done = 1'b0, m_dbz = 1'b0;
    int           div_left = 0;
    bit           dead = 1'b0;

    always @(posedge clk or posedge reset) begin
        logic [W-1:0] r, rm;
        logic dz, multi;
        if (reset) begin
            m_result = '0; m_rem = '0; m_zero = 0; m_busy = 0; m_done = 0; m_dbz = 0;
            div_left = 0; dead = 0;
        end else begin
            m_done = 0;
            if (div_left > 0) begin
                div_left--;
                if (div_left == 0) begin
                    m_result = p_result; m_rem = p_rem; m_zero = (p_result == 0);
                    m_dbz = 0; m_done = 1; m_busy = 0; dead = 1;
                end
            end else if (dead) begin
                dead = 0;
            end else if (start) begin
                golden(alu_control, a, b, r, rm, dz, multi);
                if (multi) begin
                    p_result = r; p_rem = rm; div_left = W; m_busy = 1;
                end else begin
                    m_result = r; m_rem = rm; m_zero = (r == 0); m_dbz = dz; m_done = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_result", result, m_result);
        chk("cyc_remainder", remainder, m_rem);
        chk("cyc_zero", W'(zero), W'(m_zero));
        chk("cyc_busy", W'(busy), W'(m_busy));
        chk("cyc_done", W'(done), W'(m_done));
        chk("cyc_div_by_zero", W'(div_by_zero), W'(m_dbz));
    end

    task automatic issue(input logic [2:0] c, input logic [W-1:0] x, input logic [W-1:0] y);
        @(posedge clk); #2;
        start = 1'b1; alu_control = c; a = x; b = y;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, output int busy_cycles);
        bit ok = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < 100; i++) begin
            if (done) begin ok = 1'b1; break; end
            if (busy) busy_cycles++;
            @(posedge clk); #2;
        end
        chk({name, "_timeout"}, W'(ok), W'(1));
    endtask

    task automatic quick(input string name, input logic [2:0] c, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [W-1:0] er, input logic ez);
        issue(c, x, y);
        chk({name, "_done"}, W'(done), W'(1));
        chk({name, "_result"}, result, er);
        chk({name, "_zero"}, W'(zero), W'(ez));
        chk({name, "_rem"}, remainder, '0);
    endtask

    task automatic div_lit(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic [W-1:0] eq, input logic [W-1:0] er, input int ecyc);
        int n;
        issue(3'b101, x, y);
        wait_done(name, n);
        chk({name, "_busy_cycles"}, W'(n), W'(ecyc));
        chk({name, "_quot"}, result, eq);
        chk({name, "_rem"}, remainder, er);
        @(posedge clk); #2;
        chk({name, "_done_drop"}, W'(done), W'(0));
    endtask

    logic [2:0] codes [10] = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111,
                               3'b101, 3'b101, 3'b101, 3'b011, 3'b100};

    initial begin
        int n;
        #1 reset = 1'b1;
        @(posedge clk); @(posedge clk); #2;
        chk("rst_result", result, '0);
        chk("rst_zero", W'(zero), W'(0));
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_done", W'(done), W'(0));
        chk("rst_dbz", W'(div_by_zero), W'(0));
        reset = 1'b0;

        quick("add_wrap", 3'b010, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
        @(posedge clk); #2;
        chk("add_done_drop", W'(done), W'(0));
        quick("sub", 3'b110, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0);
        quick("slt_neg", 3'b111, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
        quick("slt_pos", 3'b111, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1);
        quick("and", 3'b000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0);
        quick("or", 3'b001, 32'h0000_000F, 32'h0000_00F0, 32'h0000_00FF, 1'b0);
        quick("illegal", 3'b011, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 1'b1);
        @(posedge clk);

        div_lit("div_100_7", 32'd100, 32'd7, 32'd14, 32'd2, 32);
        div_lit("div_m7_2", 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32);
        div_lit("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 32);

        issue(3'b101, 32'd9, 32'd0);
        chk("div0_result", result, 32'hFFFF_FFFF);
        chk("div0_rem", remainder, 32'd9);
        chk("div0_dbz", W'(div_by_zero), W'(1));
        chk("div0_done", W'(done), W'(1));
        quick("add_after_div0", 3'b010, 32'd1, 32'd1, 32'd2, 1'b0);
        chk("dbz_cleared", W'(div_by_zero), W'(0));

        issue(3'b101, 32'd100, 32'd7);
        repeat (4) begin @(posedge clk); #2; end
        start = 1'b1; alu_control = 3'b010; a = 32'd3; b = 32'd4;
        @(posedge clk); #2;
        start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h0;
        wait_done("mid_start", n);
        chk("mid_start_quot", result, 32'd14);
        chk("mid_start_rem", remainder, 32'd2);
        @(posedge clk);

        issue(3'b101, 32'd1000, 32'd3);
        repeat (9) begin @(posedge clk); #2; end
        reset = 1'b1; #1;
        chk("abort_result", result, '0);
        chk("abort_busy", W'(busy), W'(0));
        chk("abort_done", W'(done), W'(0));
        @(posedge clk); #2;
        reset = 1'b0;
        repeat (30) begin
            @(posedge clk); #2;
            chk("abort_no_done", W'(done), W'(0));
        end
        div_lit("div_20_4", 32'd20, 32'd4, 32'd5, 32'd0, 32);

        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #2;
            start = ($urandom_range(0, 2) != 0);
            alu_control = codes[$urandom_range(0, 9)];
            case ($urandom_range(0, 5))
                0: begin a = $urandom; b = '0; end
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = $urandom_range(0, 300); b = $urandom_range(1, 15); end
                3: begin a = $urandom; b = 32'hFFFF_FFF0 | $urandom_range(0, 15); end
                default: begin a = $urandom; b = $urandom; end
            endcase
        end
        start = 1'b0;
        repeat (40) @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
